spi_device_apb_bridge: RTL and testbench

- SPI device (responder) that accepts transactions from an SPI host, such as the front panel SPI host interface on the other end of the cable.
- Translates each transaction into APB requester cycles, so the remote host can read and write a local APB register space.
- Sits behind a pin-level SPI port. Drives a single APB completer or an APBBridge upstream port.
- All logic runs in the APB clock domain. SCK, CS_N and MOSI are oversampled.

---
 rtl/spi_device_apb_bridge.sv | 279 +++++++++++++++++++++++++++
 tb/tb_spi_device_apb_bridge.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device_apb_bridge.sv
// spi_device_apb_bridge
// SPI mode-0 responder that turns host frames into APB requester cycles so a
// remote SPI host can read and write the local APB register space.
// Frame: opcode (0x02 write, 0x03 read), 16-bit big-endian address, then
//   write: four data bytes, little-endian
//   read : one dummy byte, then four data bytes on MISO, little-endian
// Bytes travel MSB first. SCK, CS_N and MOSI are oversampled in pclk.
//
// Ports:
//   pclk, preset_n              sole clock, async active-low reset
//   spi_sck, spi_cs_n, spi_mosi SPI inputs (mode 0, sck <= pclk/8)
//   spi_miso                    SPI output, changes after SCK falling edges
//   psel ... pslverr            APB requester port (pstrb fixed at 4'hf)
//   err                         sticky error, cleared when CS_N asserts
//
// Optional build macro SPI_DEVICE_APB_BURST_EN: frames continue with further
// words at paddr += 4; reads prefetch the next word at the last rising edge
// of the current one. Without it, bytes after the first word are ignored.
//
// state   | meaning
// IDLE    | CS_N high, no frame in progress
// OPCODE  | receiving opcode byte
// ADDR_HI | receiving address[15:8]
// ADDR_LO | receiving address[7:0]
// WDATA   | receiving write data bytes
// RDUMMY  | dummy byte while the APB read is in flight
// RDATA   | shifting read data out on MISO
// DISCARD | ignoring everything until CS_N rises

module spi_device_apb_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  err
);
    typedef enum logic [2:0] {
        IDLE, OPCODE, ADDR_HI, ADDR_LO, WDATA, RDUMMY, RDATA, DISCARD
    } state_t;
    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_t;

    state_t                 state;
    apb_t                   apb_state;
    logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
    logic                   sck_prev, cs_prev;
    logic [2:0]             bit_cnt;
    logic [1:0]             byte_cnt;
    logic [6:0]             rx_shift;
    logic [7:0]             addr_hi;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [23:0]            wdata;
    logic [31:0]            tx_shift;
    logic                   op_write;
    logic                   req_pend, req_write;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [31:0]            req_wdata;
    logic                   rd_want;   // current frame still wants the read data
    logic                   rd_got;    // read data is loaded in tx_shift
`ifdef SPI_DEVICE_APB_BURST_EN
    logic                   word_chk;  // first falling edge of a prefetched word
`endif

    logic        sck_s, cs_s, mosi_s;
    logic        sck_rise, sck_fall, byte_done;
    logic [7:0]  rx_byte;
    logic [15:0] addr_full;

    assign sck_s     = sck_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign sck_rise  = !cs_s && sck_s && !sck_prev;
    assign sck_fall  = !cs_s && !sck_s && sck_prev;
    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign addr_full = {addr_hi, rx_byte};
    assign pstrb     = 4'hf;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sck_sr    <= '0;
            cs_sr     <= '1;
            mosi_sr   <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
            state     <= IDLE;
            apb_state <= APB_IDLE;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            rx_shift  <= '0;
            addr_hi   <= '0;
            addr      <= '0;
            wdata     <= '0;
            tx_shift  <= '0;
            op_write  <= 1'b0;
            req_pend  <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            rd_want   <= 1'b0;
            rd_got    <= 1'b0;
            spi_miso  <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            err       <= 1'b0;
`ifdef SPI_DEVICE_APB_BURST_EN
            word_chk  <= 1'b0;
`endif
        end else begin
            sck_sr   <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
            cs_sr    <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            sck_prev <= sck_s;
            cs_prev  <= cs_s;

            // APB requester; a transfer always completes, even if CS_N rose.
            case (apb_state)
                APB_IDLE: begin
                    if (req_pend) begin
                        psel      <= 1'b1;
                        pwrite    <= req_write;
                        paddr     <= req_addr;
                        pwdata    <= req_wdata;
                        req_pend  <= 1'b0;
                        apb_state <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    penable   <= 1'b1;
                    apb_state <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        apb_state <= APB_IDLE;
                        if (pslverr) err <= 1'b1;
                        // Reorder so that shifting MSB-first emits byte 0 first.
                        if (!pwrite && rd_want) begin
                            tx_shift <= {prdata[7:0], prdata[15:8], prdata[23:16], prdata[31:24]};
                            rd_got   <= 1'b1;
                            rd_want  <= 1'b0;
                        end
                    end
                end
                default: apb_state <= APB_IDLE;
            endcase

            if (cs_s && !cs_prev) begin
                state    <= IDLE;
                rd_want  <= 1'b0;
                spi_miso <= 1'b0;
            end else if (!cs_s && cs_prev) begin
                state    <= OPCODE;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                rx_shift <= '0;
                rd_want  <= 1'b0;
                spi_miso <= 1'b0;
                err      <= 1'b0;
            end else begin
                if (sck_rise) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    rx_shift <= rx_byte[6:0];
                end
                if (byte_done) begin
                    case (state)
                        OPCODE: begin
                            op_write <= (rx_byte == 8'h02);
                            if (rx_byte == 8'h02 || rx_byte == 8'h03) state <= ADDR_HI;
                            else state <= DISCARD;
                        end
                        ADDR_HI: begin
                            addr_hi <= rx_byte;
                            state   <= ADDR_LO;
                        end
                        ADDR_LO: begin
                            addr     <= addr_full[ADDR_WIDTH-1:0];
                            byte_cnt <= '0;
                            if (op_write) begin
                                state <= WDATA;
                            end else begin
                                state     <= RDUMMY;
                                req_pend  <= 1'b1;
                                req_write <= 1'b0;
                                req_addr  <= addr_full[ADDR_WIDTH-1:0];
                                rd_want   <= 1'b1;
                                rd_got    <= 1'b0;
                            end
                        end
                        WDATA: begin
                            wdata <= {rx_byte, wdata[23:8]};
                            if (byte_cnt == 2'd3) begin
                                req_pend  <= 1'b1;
                                req_write <= 1'b1;
                                req_addr  <= addr;
                                req_wdata <= {rx_byte, wdata};
`ifdef SPI_DEVICE_APB_BURST_EN
                                addr     <= addr + ADDR_WIDTH'(4);
                                byte_cnt <= '0;
`else
                                state <= DISCARD;
`endif
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                        RDUMMY: begin
                            state    <= RDATA;
                            byte_cnt <= '0;
                            // Read too late: host gets all ones, late data dropped.
                            if (!rd_got) begin
                                tx_shift <= '1;
                                err      <= 1'b1;
                                rd_want  <= 1'b0;
                            end
                        end
                        RDATA: begin
                            if (byte_cnt == 2'd3) begin
`ifdef SPI_DEVICE_APB_BURST_EN
                                addr      <= addr + ADDR_WIDTH'(4);
                                req_pend  <= 1'b1;
                                req_write <= 1'b0;
                                req_addr  <= addr + ADDR_WIDTH'(4);
                                rd_want   <= 1'b1;
                                rd_got    <= 1'b0;
                                word_chk  <= 1'b1;
                                byte_cnt  <= '0;
`else
                                state <= DISCARD;
`endif
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (sck_fall) begin
                    if (state == RDATA) begin
`ifdef SPI_DEVICE_APB_BURST_EN
                        word_chk <= 1'b0;
                        if (word_chk && !rd_got) begin
                            spi_miso <= 1'b1;
                            tx_shift <= '1;
                            err      <= 1'b1;
                            rd_want  <= 1'b0;
                        end else begin
                            spi_miso <= tx_shift[31];
                            tx_shift <= {tx_shift[30:0], 1'b0};
                        end
`else
                        spi_miso <= tx_shift[31];
                        tx_shift <= {tx_shift[30:0], 1'b0};
`endif
                    end else begin
                        spi_miso <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_device_apb_bridge.sv
// Directed testbench for spi_device_apb_bridge with a small APB completer
// model that logs every completed transfer.
module tb_spi_device_apb_bridge;
    logic        pclk = 1'b0;
    logic        preset_n = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, psel, penable, pwrite, err;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int total = 0;
    int bad = 0;

    int          wait_states = 0;
    logic [31:0] rd_value = '0;
    logic        slverr_val = 1'b0;
    int wcnt = 0, n_wr = 0, n_rd = 0;
    int setup_cycles = 0, psel_cycles = 0, miso_high = 0;
    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  strb_q[$];
    logic [15:0] rd_addr_q[$];

    spi_device_apb_bridge #(.ADDR_WIDTH(16), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .err(err)
    );

    always #5 pclk = ~pclk;

    // APB completer: wait_states cycles of pready low in ACCESS, then one pready.
    always @(negedge pclk) begin
        if (psel) psel_cycles++;
        if (psel && !penable) setup_cycles++;
        if (spi_miso) miso_high++;
        if (psel && penable) begin
            if (!pready) begin
                if (wcnt >= wait_states) begin
                    pready  = 1'b1;
                    prdata  = rd_value;
                    pslverr = slverr_val;
                    if (pwrite) begin
                        n_wr++;
                        wr_addr_q.push_back(paddr);
                        wr_data_q.push_back(pwdata);
                        strb_q.push_back(pstrb);
                    end else begin
                        n_rd++;
                        rd_addr_q.push_back(paddr);
                    end
                end else begin
                    wcnt++;
                end
            end
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            wcnt    = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (4) @(negedge pclk);
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            repeat (4) @(negedge pclk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge pclk);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge pclk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge pclk);
    endtask

    task automatic wait_xfers(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (n_wr + n_rd >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        repeat (4) @(negedge pclk);
    endtask

    task automatic send_write(input logic [15:0] a, input logic [31:0] d, output logic [7:0] rx_or);
        logic [7:0] rx;
        rx_or = '0;
        spi_byte(8'h02, rx);   rx_or |= rx;
        spi_byte(a[15:8], rx); rx_or |= rx;
        spi_byte(a[7:0], rx);  rx_or |= rx;
        for (int i = 0; i < 4; i++) begin
            spi_byte(d[8*i +: 8], rx);
            rx_or |= rx;
        end
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        repeat (3) @(negedge pclk);
        total++; if (psel !== 1'b0) begin bad++; $display("FAIL rst_psel: got %b want 0", psel); end
        total++; if (penable !== 1'b0) begin bad++; $display("FAIL rst_penable: got %b want 0", penable); end
        total++; if (pwrite !== 1'b0) begin bad++; $display("FAIL rst_pwrite: got %b want 0", pwrite); end
        total++; if (paddr !== 16'h0) begin bad++; $display("FAIL rst_paddr: got %h want 0000", paddr); end
        total++; if (pwdata !== 32'h0) begin bad++; $display("FAIL rst_pwdata: got %h want 0", pwdata); end
        total++; if (pstrb !== 4'hf) begin bad++; $display("FAIL rst_pstrb: got %h want f", pstrb); end
        total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL rst_miso: got %b want 0", spi_miso); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        preset_n = 1'b1;
        repeat (4) @(negedge pclk);
    endtask

    task automatic test_write();
        int tgt = n_wr + n_rd + 1;
        int w0 = n_wr;
        int base = wr_addr_q.size();
        int s0 = setup_cycles;
        int m0 = miso_high;
        logic [7:0] rxo;
        bit ok;
        wait_states = 0;
        cs_begin();
        send_write(16'h0040, 32'hDEADBEEF, rxo);
        cs_end();
        wait_xfers(tgt, ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_done: no APB write seen"); end
        total++; if (n_wr - w0 != 1) begin bad++; $display("FAIL wr_count: got %0d want 1", n_wr - w0); end
        total++; if (wr_addr_q.size() <= base || wr_addr_q[base] !== 16'h0040) begin
            bad++; $display("FAIL wr_addr: got %h want 0040", (wr_addr_q.size() > base) ? wr_addr_q[base] : 16'hxxxx); end
        total++; if (wr_data_q.size() <= base || wr_data_q[base] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_data: got %h want deadbeef", (wr_data_q.size() > base) ? wr_data_q[base] : 32'hx); end
        total++; if (strb_q.size() <= base || strb_q[base] !== 4'hf) begin
            bad++; $display("FAIL wr_strb: got %h want f", (strb_q.size() > base) ? strb_q[base] : 4'hx); end
        total++; if (setup_cycles - s0 != 1) begin bad++; $display("FAIL wr_setup: got %0d setup cycles want 1", setup_cycles - s0); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", err); end
        total++; if (rxo !== 8'h00 || miso_high != m0) begin
            bad++; $display("FAIL wr_miso: got or=%h highs=%0d want 0", rxo, miso_high - m0); end
    endtask

    task automatic test_read();
        int tgt = n_wr + n_rd + 1;
        int r0 = n_rd;
        int base = rd_addr_q.size();
        logic [7:0] rx, rxo;
        logic [7:0] exp_b [4];
        bit ok;
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
        wait_states = 3;
        rd_value = 32'h12345678;
        rxo = '0;
        cs_begin();
        spi_byte(8'h03, rx); rxo |= rx;
        spi_byte(8'h01, rx); rxo |= rx;
        spi_byte(8'h00, rx); rxo |= rx;
        spi_byte(8'h00, rx); rxo |= rx;
        total++; if (rxo !== 8'h00) begin bad++; $display("FAIL rd_hdr_miso: got %h want 00", rxo); end
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            total++; if (rx !== exp_b[i]) begin bad++; $display("FAIL rd_byte%0d: got %h want %h", i, rx, exp_b[i]); end
        end
        cs_end();
        wait_xfers(tgt, ok);
        total++; if (n_rd - r0 != 1) begin bad++; $display("FAIL rd_count: got %0d want 1", n_rd - r0); end
        total++; if (rd_addr_q.size() <= base || rd_addr_q[base] !== 16'h0100) begin
            bad++; $display("FAIL rd_addr: got %h want 0100", (rd_addr_q.size() > base) ? rd_addr_q[base] : 16'hxxxx); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", err); end
    endtask

    task automatic test_timeout();
        int tgt = n_wr + n_rd + 1;
        int base = wr_addr_q.size();
        logic [7:0] rx, rxo;
        bit ok;
        wait_states = 200;
        rd_value = 32'hA5A5A5A5;
        cs_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h08, rx);
        spi_byte(8'h00, rx);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            total++; if (rx !== 8'hFF) begin bad++; $display("FAIL to_byte%0d: got %h want ff", i, rx); end
        end
        cs_end();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err); end
        wait_xfers(tgt, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_late_done: late read never completed"); end
        wait_states = 0;
        tgt = n_wr + n_rd + 1;
        cs_begin();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_clear: got %b want 0", err); end
        send_write(16'h0044, 32'hCAFEF00D, rxo);
        cs_end();
        wait_xfers(tgt, ok);
        total++; if (wr_data_q.size() <= base || wr_data_q[base] !== 32'hCAFEF00D) begin
            bad++; $display("FAIL to_next_wr: got %h want cafef00d", (wr_data_q.size() > base) ? wr_data_q[base] : 32'hx); end
    endtask

    task automatic test_abort();
        int w0 = n_wr;
        int p0 = psel_cycles;
        int base = wr_addr_q.size();
        int tgt;
        logic [7:0] rx, rxo;
        bit ok;
        wait_states = 0;
        cs_begin();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h40, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        cs_end();
        repeat (100) @(negedge pclk);
        total++; if (n_wr != w0 || psel_cycles != p0) begin
            bad++; $display("FAIL abort_noapb: got writes=%0d psel_cycles=%0d want 0", n_wr - w0, psel_cycles - p0); end
        tgt = n_wr + n_rd + 1;
        cs_begin();
        send_write(16'h0048, 32'h11223344, rxo);
        cs_end();
        wait_xfers(tgt, ok);
        total++; if (wr_addr_q.size() <= base || wr_addr_q[base] !== 16'h0048 || wr_data_q[base] !== 32'h11223344) begin
            bad++; $display("FAIL abort_next_wr: got n=%0d want addr 0048 data 11223344", wr_addr_q.size() - base); end
    endtask

    task automatic test_invalid();
        int p0 = psel_cycles;
        int m0 = miso_high;
        logic [7:0] rx, rxo;
        logic [7:0] tail [6];
        tail = '{8'h02, 8'h00, 8'h40, 8'hAA, 8'hBB, 8'hCC};
        rxo = '0;
        cs_begin();
        spi_byte(8'h55, rx); rxo |= rx;
        for (int i = 0; i < 6; i++) begin
            spi_byte(tail[i], rx);
            rxo |= rx;
        end
        cs_end();
        repeat (50) @(negedge pclk);
        total++; if (psel_cycles != p0) begin bad++; $display("FAIL inv_psel: got %0d psel cycles want 0", psel_cycles - p0); end
        total++; if (rxo !== 8'h00 || miso_high != m0) begin
            bad++; $display("FAIL inv_miso: got or=%h highs=%0d want 0", rxo, miso_high - m0); end
    endtask

    task automatic test_slverr();
        int tgt = n_wr + n_rd + 1;
        int base = wr_addr_q.size();
        logic [7:0] rxo;
        bit ok;
        wait_states = 1;
        slverr_val = 1'b1;
        cs_begin();
        send_write(16'h004C, 32'h04030201, rxo);
        wait_xfers(tgt, ok);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL slverr_err: got %b want 1", err); end
        cs_end();
        slverr_val = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL slverr_sticky: got %b want 1", err); end
        total++; if (wr_data_q.size() <= base || wr_data_q[base] !== 32'h04030201) begin
            bad++; $display("FAIL slverr_data: got %h want 04030201", (wr_data_q.size() > base) ? wr_data_q[base] : 32'hx); end
    endtask

    task automatic test_burst();
        int w0 = n_wr;
        int tgt = n_wr + n_rd + 1;
        int base = wr_addr_q.size();
        logic [7:0] rx;
        logic [7:0] hdr [3];
        bit ok;
        wait_states = 0;
`ifdef SPI_DEVICE_APB_BURST_EN
        hdr = '{8'h02, 8'hFF, 8'hFC};
        tgt = tgt + 1;
`else
        hdr = '{8'h02, 8'h00, 8'hFC};
`endif
        cs_begin();
        for (int i = 0; i < 3; i++) spi_byte(hdr[i], rx);
        for (int i = 1; i <= 8; i++) spi_byte(8'(i), rx);
        cs_end();
        wait_xfers(tgt, ok);
        repeat (100) @(negedge pclk);
`ifdef SPI_DEVICE_APB_BURST_EN
        total++; if (n_wr - w0 != 2) begin bad++; $display("FAIL burst_count: got %0d want 2", n_wr - w0); end
        total++; if (wr_addr_q.size() < base + 2 || wr_addr_q[base] !== 16'hFFFC || wr_addr_q[base+1] !== 16'h0000) begin
            bad++; $display("FAIL burst_addr: got n=%0d want fffc then 0000", wr_addr_q.size() - base); end
        total++; if (wr_data_q.size() < base + 2 || wr_data_q[base] !== 32'h04030201 || wr_data_q[base+1] !== 32'h08070605) begin
            bad++; $display("FAIL burst_data: got n=%0d want 04030201 then 08070605", wr_data_q.size() - base); end
`else
        total++; if (n_wr - w0 != 1) begin bad++; $display("FAIL single_count: got %0d want 1", n_wr - w0); end
        total++; if (wr_addr_q.size() <= base || wr_addr_q[base] !== 16'h00FC || wr_data_q[base] !== 32'h04030201) begin
            bad++; $display("FAIL single_word: got n=%0d want addr 00fc data 04030201", wr_addr_q.size() - base); end
`endif
    endtask

    task automatic test_back_to_back();
        int tgt = n_wr + n_rd + 2;
        int base = wr_addr_q.size();
        int s0 = setup_cycles;
        logic [7:0] rxo;
        bit ok;
        wait_states = 500;
        cs_begin();
        send_write(16'h0050, 32'hA4A3A2A1, rxo);
        cs_end();
        cs_begin();
        send_write(16'h0054, 32'hB4B3B2B1, rxo);
        cs_end();
        wait_xfers(tgt, ok);
        wait_states = 0;
        total++; if (!ok) begin bad++; $display("FAIL b2b_done: got %0d transfers want 2", n_wr + n_rd - tgt + 2); end
        total++; if (wr_addr_q.size() < base + 2 || wr_addr_q[base] !== 16'h0050 || wr_addr_q[base+1] !== 16'h0054) begin
            bad++; $display("FAIL b2b_addr: got n=%0d want 0050 then 0054", wr_addr_q.size() - base); end
        total++; if (wr_data_q.size() < base + 2 || wr_data_q[base] !== 32'hA4A3A2A1 || wr_data_q[base+1] !== 32'hB4B3B2B1) begin
            bad++; $display("FAIL b2b_data: got n=%0d want a4a3a2a1 then b4b3b2b1", wr_data_q.size() - base); end
        total++; if (setup_cycles - s0 != 2) begin bad++; $display("FAIL b2b_setup: got %0d want 2", setup_cycles - s0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_abort();
        test_invalid();
        test_slverr();
        test_burst();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
